idwt_cell: RTL and testbench
============================

Name: idwt_cell

Overview:
- Single-stage inverse DWT (synthesis) cell. Reconstructs a full-rate signal from one approximation/detail sample pair produced by the analysis chain.
- Each accepted pair is upsampled by 2 and filtered with the low-pass synthesis filter G_LP and the high-pass synthesis filter G_HP, in polyphase form.
- Emits two reconstructed samples per input pair on consecutive cycles.
- Building block for the multi-stage reconstruction path, chained approximation-to-approximation in the same way as the analysis cells.

Parameters:
- IN_WIDTH, 12, signed width of a_in / d_in
- OUT_WIDTH, 12, signed width of y_out
- COEFF_WIDTH, 12, signed coefficient width, fixed point with FRA_WIDTH fractional bits
- FRA_WIDTH, 8, fractional bits of the quantization scheme
- MAC_WIDTH, 26, accumulator width; must be >= IN_WIDTH + COEFF_WIDTH + $clog2(N)
- N, 4, filter taps, even, >= 2
- G_LP, G_LP_DEFAULT, packed N*COEFF_WIDTH low-pass synthesis coefficients, tap 0 in the LSBs
- G_HP, G_HP_DEFAULT, packed N*COEFF_WIDTH high-pass synthesis coefficients, tap 0 in the LSBs
- IDWT_INIT, 0, output phase: 0 = even sample first, 1 = odd sample first

Ports:
- clk  in  1  system clock, rising edge
- rst  in  1  asynchronous, active-high reset
- in_enable  in  1  single-cycle strobe; a_in/d_in valid
- a_in  in  IN_WIDTH  signed approximation sample
- d_in  in  IN_WIDTH  signed detail sample
- out_enable  out  1  single-cycle strobe; y_out valid
- y_out  out  OUT_WIDTH  signed reconstructed sample
- overflow  out  1  sticky: an input strobe was dropped

Behaviour:
- History: two shift registers a_h[0..N/2-1] and d_h[0..N/2-1]. On an accepted strobe, a_in/d_in enter index 0; older entries shift up by one.
- Polyphase MAC, with k indexing history:
  - even output = sum over j of G_LP[2j]*a_h[j] + G_HP[2j]*d_h[j]
  - odd output = same sum using taps 2j+1
  - full precision in MAC_WIDTH.
- Output quantization: add 1<<(FRA_WIDTH-1), arithmetic shift right by FRA_WIDTH (round half up), saturate to the signed OUT_WIDTH range [-2^(OUT_WIDTH-1), 2^(OUT_WIDTH-1)-1].
- FSM states: IDLE, PH0, PH1.
  - IDLE: on in_enable -> PH0, history updated.
  - PH0: emit first-phase sample -> PH1. in_enable in this state is dropped: history unchanged, overflow set.
  - PH1: emit second-phase sample. If in_enable -> PH0 (accepted, history updated); else -> IDLE.
- Phase mapping: IDWT_INIT=0 gives PH0 = even, PH1 = odd; IDWT_INIT=1 swaps them.
- Latency: strobe in cycle t -> out_enable high in cycles t+2 (first phase) and t+3 (second phase), y_out registered.
- Throughput: maximum one pair every 2 cycles; back-to-back pairs at that rate produce continuous out_enable.
- y_out holds its last value while out_enable is low.
- Reset (asynchronous, any time including mid-pair): state=IDLE; all history=0; y_out=0; out_enable=0; overflow=0. A pending second-phase output is discarded.
- overflow clears only on reset.
- Startup: history starts at zero, so the first N/2-1 pairs include zero-padding terms. No output suppression.

Decomposition:
- Shared coefficient include (same file as the analysis coefficients) gains G_LP_DEFAULT / G_HP_DEFAULT synthesis vectors and N_DWT.
- State encoding is local to the module.
- One sub-module, idwt_mac: combinational polyphase dot product plus round/saturate, with a phase-select input. Instantiated once in idwt_cell.
- idwt_nstage (a later block) chains idwt_cell instances.

Test Plan:
- Setup for all cases: G_LP={256,256,0,0}, G_HP={256,-256,0,0}, IDWT_INIT=0.
- Basic pair: a_in=100, d_in=20 strobed at t -> out_enable at t+2 with y_out=120, at t+3 with y_out=80; overflow=0.
- Saturation: a_in=2047, d_in=2047 -> y_out=2047 (sum 4094 clipped), then 0; a_in=-2048, d_in=-2048 -> -2048, then 0.
- Rounding, with G_LP={128,128,0,0} and G_HP=0: a_in=3 -> 2, 2; a_in=-3 -> -1, -1.
- Rate and overflow: strobes at t and t+1 -> second strobe dropped, overflow=1 from t+2, outputs only 120/80 from the first pair. Strobes at t and t+2 -> four consecutive out_enable cycles, overflow stays 0.
- Default coefficients, impulse a_in=256 then zeros -> first four outputs equal G_LP taps 0..3 after rounding. Then set IDWT_INIT=1 -> pair order swapped (odd tap first).
- Reset mid-pair: assert rst in cycle t+2 -> out_enable=0 at t+3, y_out=0, history cleared; the next strobe a=100, d=20 reproduces 120/80.

Source files
------------

// File: rtl/idwt_cell_pkg.sv
// Shared wavelet coefficients for the reconstruction path: default Db2-style
// synthesis filters in Q8, packed with tap 0 in the least significant bits.
package idwt_cell_pkg;

  localparam int N_DWT = 4;
  localparam int COEFF_WIDTH_DWT = 12;

  // Low-pass taps 0..3 = 124, 214, 57, -33; high-pass is its alternating-sign mirror.
  localparam logic [N_DWT*COEFF_WIDTH_DWT-1:0] G_LP_DEFAULT =
    {-12'sd33, 12'sd57, 12'sd214, 12'sd124};
  localparam logic [N_DWT*COEFF_WIDTH_DWT-1:0] G_HP_DEFAULT =
    {-12'sd124, 12'sd214, -12'sd57, -12'sd33};

endpackage

// File: rtl/idwt_mac.sv
// Combinational polyphase dot product over the approximation/detail history,
// followed by round-half-up and saturation to the output width.
module idwt_mac #(
  parameter int IN_WIDTH    = 12,
  parameter int OUT_WIDTH   = 12,
  parameter int COEFF_WIDTH = 12,
  parameter int FRA_WIDTH   = 8,
  parameter int MAC_WIDTH   = 26,
  parameter int N           = 4,
  parameter logic [N*COEFF_WIDTH-1:0] G_LP = '0,
  parameter logic [N*COEFF_WIDTH-1:0] G_HP = '0
) (
  input  logic                           phase_odd,
  input  logic [N/2-1:0][IN_WIDTH-1:0]   a_h,
  input  logic [N/2-1:0][IN_WIDTH-1:0]   d_h,
  output logic [OUT_WIDTH-1:0]           y
);

  localparam logic signed [MAC_WIDTH-1:0] Y_MAX = MAC_WIDTH'((1 << (OUT_WIDTH-1)) - 1);
  localparam logic signed [MAC_WIDTH-1:0] Y_MIN = -Y_MAX - 1;
  localparam logic signed [MAC_WIDTH-1:0] ROUND = MAC_WIDTH'(1 << (FRA_WIDTH-1));

  function automatic logic signed [MAC_WIDTH-1:0] coeff(
    input logic [N*COEFF_WIDTH-1:0] v, input int k);
    return MAC_WIDTH'($signed(v[k*COEFF_WIDTH +: COEFF_WIDTH]));
  endfunction

  function automatic logic signed [MAC_WIDTH-1:0] sample(input logic [IN_WIDTH-1:0] s);
    return MAC_WIDTH'($signed(s));
  endfunction

  logic signed [MAC_WIDTH-1:0] acc;
  logic signed [MAC_WIDTH-1:0] rnd;
  logic signed [MAC_WIDTH-1:0] q;

  always_comb begin
    acc = '0;
    for (int j = 0; j < N/2; j++) begin
      acc = acc + coeff(G_LP, 2*j + int'(phase_odd)) * sample(a_h[j])
                + coeff(G_HP, 2*j + int'(phase_odd)) * sample(d_h[j]);
    end
    rnd = acc + ROUND;
    q   = rnd >>> FRA_WIDTH;
    if (q > Y_MAX)      y = Y_MAX[OUT_WIDTH-1:0];
    else if (q < Y_MIN) y = Y_MIN[OUT_WIDTH-1:0];
    else                y = q[OUT_WIDTH-1:0];
  end

endmodule

// File: rtl/idwt_cell.sv
// Single-stage inverse DWT cell: takes one approximation/detail pair and emits
// two reconstructed samples on consecutive cycles.
module idwt_cell
  import idwt_cell_pkg::*;
#(
  parameter int IN_WIDTH    = 12,
  parameter int OUT_WIDTH   = 12,
  parameter int COEFF_WIDTH = COEFF_WIDTH_DWT,
  parameter int FRA_WIDTH   = 8,
  parameter int MAC_WIDTH   = 26,
  parameter int N           = N_DWT,
  parameter logic [N*COEFF_WIDTH-1:0] G_LP = G_LP_DEFAULT,
  parameter logic [N*COEFF_WIDTH-1:0] G_HP = G_HP_DEFAULT,
  parameter int IDWT_INIT   = 0
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic                 in_enable,
  input  logic [IN_WIDTH-1:0]  a_in,
  input  logic [IN_WIDTH-1:0]  d_in,
  output logic                 out_enable,
  output logic [OUT_WIDTH-1:0] y_out,
  output logic                 overflow
);

  typedef enum logic [1:0] {IDLE, PH0, PH1} state_t;

  localparam logic FIRST_ODD = (IDWT_INIT != 0);

  state_t                       state;
  logic [N/2-1:0][IN_WIDTH-1:0] a_h;
  logic [N/2-1:0][IN_WIDTH-1:0] d_h;
  logic                         phase_odd;
  logic [OUT_WIDTH-1:0]         mac_y;

  assign phase_odd = (state == PH0) ? FIRST_ODD : ~FIRST_ODD;

  idwt_mac #(
    .IN_WIDTH(IN_WIDTH), .OUT_WIDTH(OUT_WIDTH), .COEFF_WIDTH(COEFF_WIDTH),
    .FRA_WIDTH(FRA_WIDTH), .MAC_WIDTH(MAC_WIDTH), .N(N),
    .G_LP(G_LP), .G_HP(G_HP)
  ) u_mac (
    .phase_odd(phase_odd),
    .a_h(a_h),
    .d_h(d_h),
    .y(mac_y)
  );

  // Outputs are computed from the history as it stands; a pair accepted in PH1
  // shifts in at the same edge, so it only affects the following two phases.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state      <= IDLE;
      a_h        <= '0;
      d_h        <= '0;
      y_out      <= '0;
      out_enable <= 1'b0;
      overflow   <= 1'b0;
    end else begin
      out_enable <= 1'b0;
      case (state)
        IDLE: begin
          if (in_enable) begin
            for (int k = N/2-1; k > 0; k--) begin
              a_h[k] <= a_h[k-1];
              d_h[k] <= d_h[k-1];
            end
            a_h[0] <= a_in;
            d_h[0] <= d_in;
            state  <= PH0;
          end
        end
        PH0: begin
          y_out      <= mac_y;
          out_enable <= 1'b1;
          state      <= PH1;
          if (in_enable) overflow <= 1'b1;
        end
        PH1: begin
          y_out      <= mac_y;
          out_enable <= 1'b1;
          if (in_enable) begin
            for (int k = N/2-1; k > 0; k--) begin
              a_h[k] <= a_h[k-1];
              d_h[k] <= d_h[k-1];
            end
            a_h[0] <= a_in;
            d_h[0] <= d_in;
            state  <= PH0;
          end else begin
            state <= IDLE;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_idwt_cell.sv
// Bench for idwt_cell: four instances (test filters, rounding filters, default
// filters in both output phases) share stimulus; one is selected at a time.
module tb_idwt_cell;
  import idwt_cell_pkg::*;

  localparam logic [47:0] LP_T = {12'sd0, 12'sd0, 12'sd256, 12'sd256};
  localparam logic [47:0] HP_T = {12'sd0, 12'sd0, -12'sd256, 12'sd256};
  localparam logic [47:0] LP_R = {12'sd0, 12'sd0, 12'sd128, 12'sd128};
  localparam logic [47:0] HP_R = '0;
  localparam logic [47:0] LP_D = G_LP_DEFAULT;

  logic clk = 1'b0;
  logic rst = 1'b1;
  logic in_enable = 1'b0;
  logic signed [11:0] a_in = '0;
  logic signed [11:0] d_in = '0;
  int sel = 0;
  int cyc = 0;
  int checks = 0;
  int errors = 0;

  int exp_q[$];
  int exp_cyc_q[$];

  logic en_0, en_1, en_2, en_3;
  logic oe_0, oe_1, oe_2, oe_3;
  logic ov_0, ov_1, ov_2, ov_3;
  logic signed [11:0] y_0, y_1, y_2, y_3;
  logic mon_oe, mon_ov;
  logic signed [11:0] mon_y;

  // Clock and reset
  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  assign en_0 = in_enable && (sel == 0);
  assign en_1 = in_enable && (sel == 1);
  assign en_2 = in_enable && (sel == 2);
  assign en_3 = in_enable && (sel == 3);

  assign mon_oe = (sel == 0) ? oe_0 : (sel == 1) ? oe_1 : (sel == 2) ? oe_2 : oe_3;
  assign mon_ov = (sel == 0) ? ov_0 : (sel == 1) ? ov_1 : (sel == 2) ? ov_2 : ov_3;
  assign mon_y  = (sel == 0) ? y_0  : (sel == 1) ? y_1  : (sel == 2) ? y_2  : y_3;

  idwt_cell #(.G_LP(LP_T), .G_HP(HP_T), .IDWT_INIT(0)) dut_t (
    .clk(clk), .rst(rst), .in_enable(en_0), .a_in(a_in), .d_in(d_in),
    .out_enable(oe_0), .y_out(y_0), .overflow(ov_0));
  idwt_cell #(.G_LP(LP_R), .G_HP(HP_R), .IDWT_INIT(0)) dut_r (
    .clk(clk), .rst(rst), .in_enable(en_1), .a_in(a_in), .d_in(d_in),
    .out_enable(oe_1), .y_out(y_1), .overflow(ov_1));
  idwt_cell #(.IDWT_INIT(0)) dut_d0 (
    .clk(clk), .rst(rst), .in_enable(en_2), .a_in(a_in), .d_in(d_in),
    .out_enable(oe_2), .y_out(y_2), .overflow(ov_2));
  idwt_cell #(.IDWT_INIT(1)) dut_d1 (
    .clk(clk), .rst(rst), .in_enable(en_3), .a_in(a_in), .d_in(d_in),
    .out_enable(oe_3), .y_out(y_3), .overflow(ov_3));

  task automatic check(input string tag, input int got, input int exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s got=%0d exp=%0d (cycle %0d)", tag, got, exp, cyc);
    end
  endtask

  function automatic int lp_tap(input int k);
    return int'($signed(LP_D[k*12 +: 12]));
  endfunction

  // Driver: raise a strobe for the cycle starting at this negedge and queue
  // the two samples it must produce two and three cycles later.
  task automatic pair(input int a, input int d, input int e0, input int e1);
    @(negedge clk);
    a_in = 12'(a);
    d_in = 12'(d);
    in_enable = 1'b1;
    exp_q.push_back(e0);
    exp_cyc_q.push_back(cyc + 2);
    exp_q.push_back(e1);
    exp_cyc_q.push_back(cyc + 3);
  endtask

  task automatic idle();
    @(negedge clk);
    in_enable = 1'b0;
  endtask

  task automatic wait_cycles(input int n);
    repeat (n) @(negedge clk);
  endtask

  // Scoreboard: every out_enable must match the head of the queue in value
  // and cycle; a head whose cycle passes without out_enable is a miss.
  always @(negedge clk) begin
    if (!rst) begin
      if (mon_oe) begin
        if (exp_q.size() == 0) begin
          check("spurious_out", 1, 0);
        end else begin
          check("y_out", int'(mon_y), exp_q[0]);
          check("out_cycle", cyc, exp_cyc_q[0]);
          void'(exp_q.pop_front());
          void'(exp_cyc_q.pop_front());
        end
      end else if (exp_cyc_q.size() != 0 && exp_cyc_q[0] <= cyc) begin
        check("missing_out", 0, 1);
        void'(exp_q.pop_front());
        void'(exp_cyc_q.pop_front());
      end
    end
  end

  initial begin
    wait_cycles(3);
    check("rst_out_enable", int'(oe_0), 0);
    check("rst_y_out", int'(y_0), 0);
    check("rst_overflow", int'(ov_0), 0);
    rst = 1'b0;
    wait_cycles(2);

    // Basic pair and output hold
    sel = 0;
    pair(100, 20, 120, 80);
    idle();
    wait_cycles(4);
    check("basic_overflow", int'(mon_ov), 0);
    check("hold_y_out", int'(mon_y), 80);

    // Saturation both ways
    pair(2047, 2047, 2047, 0);
    idle();
    wait_cycles(3);
    pair(-2048, -2048, -2048, 0);
    idle();
    wait_cycles(4);

    // Back-to-back at full rate: four consecutive outputs
    pair(100, 20, 120, 80);
    idle();
    pair(30, -10, 20, 40);
    idle();
    wait_cycles(5);
    check("b2b_overflow", int'(mon_ov), 0);

    // Strobe one cycle after the previous one is dropped
    pair(100, 20, 120, 80);
    @(negedge clk);
    a_in = 12'sd500;
    d_in = 12'sd500;
    idle();
    check("drop_overflow", int'(mon_ov), 1);
    wait_cycles(4);
    check("drop_overflow_sticky", int'(mon_ov), 1);

    // Rounding half up on both signs
    sel = 1;
    pair(3, 0, 2, 2);
    idle();
    wait_cycles(3);
    pair(-3, 0, -1, -1);
    idle();
    wait_cycles(4);

    // Default filters, impulse: even phase first, then odd phase first
    sel = 2;
    pair(256, 0, lp_tap(0), lp_tap(1));
    idle();
    pair(0, 0, lp_tap(2), lp_tap(3));
    idle();
    wait_cycles(4);
    sel = 3;
    pair(256, 0, lp_tap(1), lp_tap(0));
    idle();
    pair(0, 0, lp_tap(3), lp_tap(2));
    idle();
    wait_cycles(4);

    // Reset while the second phase is pending
    sel = 0;
    @(negedge clk);
    a_in = 12'sd100;
    d_in = 12'sd20;
    in_enable = 1'b1;
    exp_q.push_back(120);
    exp_cyc_q.push_back(cyc + 2);
    idle();
    @(negedge clk);
    #1;
    rst = 1'b1;
    exp_q.delete();
    exp_cyc_q.delete();
    @(negedge clk);
    check("midrst_out_enable", int'(oe_0), 0);
    check("midrst_y_out", int'(y_0), 0);
    check("midrst_overflow", int'(ov_0), 0);
    rst = 1'b0;
    wait_cycles(2);
    pair(100, 20, 120, 80);
    idle();
    wait_cycles(4);
    // History of the default-filter cell must be cleared as well
    sel = 2;
    pair(0, 0, 0, 0);
    idle();
    wait_cycles(4);
    check("d0_overflow", int'(mon_ov), 0);

    check("queue_drained", exp_q.size(), 0);
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
